rf_write_arbiter: RTL

Shares the register file's single write port between three writers: the pipeline WB stage, the exception unit (EPC/cause into $26/$27), and the multi-cycle multiply/divide unit returning GPR results. It sits between those sources and the register file's `wr`/`addr3`/`data3` inputs, queues deferred writes, and raises `stall_req` to ID when a decoding instruction reads a register with a queued write. The port is driven combinationally in the same cycle so the register file captures it on the negative clock edge.

---
 rtl/rf_write_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// WB stage, the exception unit and the multiply/divide unit.
// Fixed priority per cycle: WB > held exception > mult/div FIFO head.
// Port outputs are combinational so the register file captures them on negedge.
// Optional feature: define RFARB_STARVE_EN to enable the FIFO-head starvation
// guard (forces stall_req so ID bubbles drain WB and the head gets the port).
module rf_write_arbiter #(
  parameter int MD_DEPTH     = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_wr,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        exc_req,
  input  logic [4:0]  exc_addr,
  input  logic [31:0] exc_data,
  output logic        exc_ack,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_addr,
  input  logic [31:0] md_data,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        stall_req,
  output logic        rf_wr,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam int PW = $clog2(MD_DEPTH);

  // Mult/div FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [4:0]  fifo_addr [MD_DEPTH];
  logic [31:0] fifo_data [MD_DEPTH];
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  logic [PW:0] fifo_count;
  logic        fifo_empty;
  logic        fifo_full;

  // One-entry exception hold register
  logic        hold_valid;
  logic [4:0]  hold_addr;
  logic [31:0] hold_data;

  // Request decode and grants
  logic        wb_act;
  logic        exc_pend;
  logic [4:0]  exc_sel_addr;
  logic [31:0] exc_sel_data;
  logic        grant_wb;
  logic        grant_exc;
  logic        grant_md;
  logic        md_push;

  // Scoreboard
  logic [MD_DEPTH-1:0] entry_valid;
  logic [MD_DEPTH-1:0] rs_hit;
  logic [MD_DEPTH-1:0] rt_hit;
  logic                rs_pending;
  logic                rt_pending;
  logic                starve_stall;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign md_ready   = !fifo_full;

  // WB to $0 is not a request; an arriving exception bypasses the hold register
  assign wb_act       = wb_wr && (wb_addr != 5'd0);
  assign exc_pend     = exc_req || hold_valid;
  assign exc_sel_addr = exc_req ? exc_addr : hold_addr;
  assign exc_sel_data = exc_req ? exc_data : hold_data;

  // All grants are suppressed while reset is asserted so the port stays quiet
  assign grant_wb  = reset && wb_act;
  assign grant_exc = reset && !wb_act && exc_pend;
  assign grant_md  = reset && !wb_act && !exc_pend && !fifo_empty;

  // Results for $0 are accepted but never stored
  assign md_push = reset && md_valid && md_ready && (md_addr != 5'd0);

  assign exc_ack = grant_exc;

  // Drive the register file write port from the winning source
  always_comb begin
    rf_wr   = 1'b0;
    rf_addr = 5'd0;
    rf_data = 32'd0;
    if (grant_wb) begin
      rf_wr   = 1'b1;
      rf_addr = wb_addr;
      rf_data = wb_data;
    end else if (grant_exc) begin
      rf_wr   = 1'b1;
      rf_addr = exc_sel_addr;
      rf_data = exc_sel_data;
    end else if (grant_md) begin
      rf_wr   = 1'b1;
      rf_addr = fifo_addr[rd_ptr[PW-1:0]];
      rf_data = fifo_data[rd_ptr[PW-1:0]];
    end
  end

  // Per-entry occupancy and source-register match against queued destinations
  genvar gi;
  generate
    for (gi = 0; gi < MD_DEPTH; gi++) begin : g_sb
      localparam logic [PW-1:0] IDX = PW'(gi);
      logic [PW-1:0] offset;
      assign offset          = IDX - rd_ptr[PW-1:0];
      assign entry_valid[gi] = ({1'b0, offset} < fifo_count);
      assign rs_hit[gi]      = entry_valid[gi] && (fifo_addr[gi] == id_rs);
      assign rt_hit[gi]      = entry_valid[gi] && (fifo_addr[gi] == id_rt);
    end
  endgenerate

  assign rs_pending = (id_rs != 5'd0) &&
                      ((|rs_hit) || (hold_valid && (hold_addr == id_rs)));
  assign rt_pending = (id_rt != 5'd0) &&
                      ((|rt_hit) || (hold_valid && (hold_addr == id_rt)));

  assign stall_req = rs_pending || rt_pending || starve_stall;

`ifdef RFARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Count cycles the FIFO head waits; saturate at the limit, clear on pop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (grant_md) begin
      starve_cnt <= '0;
    end else if (!fifo_empty && (starve_cnt != SW'(STARVE_LIMIT))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Stall from the STARVE_LIMIT-th consecutive wait cycle until the head pops
  assign starve_stall = !fifo_empty && (starve_cnt >= SW'(STARVE_LIMIT - 1));
`else
  assign starve_stall = 1'b0;
`endif

  // Pointer and hold-register state; pop/push/clear take effect at grant-cycle end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      hold_valid <= 1'b0;
      hold_addr  <= 5'd0;
      hold_data  <= 32'd0;
    end else begin
      if (md_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_md) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (grant_exc) begin
        hold_valid <= 1'b0;
      end else if (exc_req) begin
        // A second request while one is held overwrites the older one
        hold_valid <= 1'b1;
        hold_addr  <= exc_addr;
        hold_data  <= exc_data;
      end
    end
  end

  // FIFO payload storage; validity comes solely from the pointers
  always_ff @(posedge clk) begin
    if (md_push) begin
      fifo_addr[wr_ptr[PW-1:0]] <= md_addr;
      fifo_data[wr_ptr[PW-1:0]] <= md_data;
    end
  end

endmodule
